pio_clkdiv_frac: RTL

N-channel fractional clock-enable generator for the PIO state machines. Each channel emits a single-cycle tick at an average rate of inclk / (div_int + div_frac/2^FRAC_W). It generalises the single-channel integer divider with per-channel enable, restart for phase alignment, fractional dithering, and glitch-free divisor update at period boundaries. Ticks gate state-machine execution in the same inclk domain; no derived clock is produced.

---
 rtl/pio_clkdiv_pkg.sv | 12 +
 rtl/pio_clkdiv_chan.sv | 46 ++++
 rtl/pio_clkdiv_frac.sv | 28 ++
 3 files changed

// File: rtl/pio_clkdiv_pkg.sv
// pio_clkdiv_pkg: shared widths, divisor record and integer-divisor mapping for the PIO clock dividers
package pio_clkdiv_pkg;
  localparam int DEF_INT_W  = 16;
  localparam int DEF_FRAC_W = 8;
  typedef struct packed {
    logic [DEF_INT_W-1:0]  ipart;
    logic [DEF_FRAC_W-1:0] fpart;
  } div_t;
  function automatic logic [DEF_INT_W:0] eff_int(input logic [DEF_INT_W-1:0] d);
    return {d == '0, d};
  endfunction
endpackage

// File: rtl/pio_clkdiv_chan.sv
// pio_clkdiv_chan: one fractional clock-enable channel (countdown plus dither accumulator)
module pio_clkdiv_chan
  import pio_clkdiv_pkg::*;
#(
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              inclk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              restart_i,
  input  logic [INT_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              tick_o
);
  logic [INT_W:0]  cnt_q, cnt_d, eff;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0] sum;
  logic tick_q, tick_d, bnd;
  if (INT_W == DEF_INT_W) begin : g_pkg
    assign eff = eff_int(div_int_i);
  end else begin : g_gen
    assign eff = {div_int_i == '0, div_int_i};
  end
  assign sum = {1'b0, acc_q} + {1'b0, div_frac_i};
  assign bnd = cnt_q <= (INT_W+1)'(1);
  // next state: restart clears, disable freezes, boundary reloads with dithered length, else count down
  always_comb begin
    cnt_d  = restart_i ? '0 : !en_i ? cnt_q : bnd ? eff + (INT_W+1)'(sum[FRAC_W]) : cnt_q - (INT_W+1)'(1);
    acc_d  = restart_i ? '0 : (en_i && bnd) ? sum[FRAC_W-1:0] : acc_q;
    tick_d = !restart_i && en_i && bnd;
  end
  // channel state registers
  always_ff @(posedge inclk) begin
    if (reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end
  assign tick_o = tick_q;
endmodule

// File: rtl/pio_clkdiv_frac.sv
// pio_clkdiv_frac: NCH independent fractional clock-enable generators for the PIO state machines
module pio_clkdiv_frac
  import pio_clkdiv_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                  inclk,
  input  logic                  reset,
  input  logic [NCH-1:0]        en,
  input  logic [NCH-1:0]        restart,
  input  logic [NCH*INT_W-1:0]  div_int,
  input  logic [NCH*FRAC_W-1:0] div_frac,
  output logic [NCH-1:0]        tick
);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pio_clkdiv_chan #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_chan (
      .inclk      (inclk),
      .reset      (reset),
      .en_i       (en[c]),
      .restart_i  (restart[c]),
      .div_int_i  (div_int[c*INT_W +: INT_W]),
      .div_frac_i (div_frac[c*FRAC_W +: FRAC_W]),
      .tick_o     (tick[c])
    );
  end
endmodule
